// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment display controller for 1..8 digits.
// Scans one digit per TICK_DIV-cycle slot. Loads go into shadow registers,
// which move to the active set only at a frame boundary, so a frame never
// shows a mix of old and new values. Also provides leading-zero blanking
// and 16-level PWM brightness within each slot.
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   value, dp_in    - hex nibbles and decimal points, digit 0 rightmost
//   load            - strobe capturing value/dp_in/blank_lz/brightness
//   blank_lz        - leading-zero blanking enable
//   brightness      - 0 = 1/16 duty .. 15 = full duty
//   seg, dp, an     - active-low segment, decimal point and anode pins
//   frame_done      - one-cycle pulse after each frame boundary
module seg7_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned TICK_DIV   = 3125
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [3:0]              brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;

  logic [CNT_W-1:0]      tick_q, tick_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  logic [VAL_W-1:0]      sh_val_q;
  logic [NUM_DIGITS-1:0] sh_dp_q;
  logic                  sh_blz_q;
  logic [3:0]            sh_bri_q;

  logic [VAL_W-1:0]      act_val_q;
  logic [NUM_DIGITS-1:0] act_dp_q;
  logic                  act_blz_q;
  logic [3:0]            act_bri_q;

  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fd_q;

  logic                  tick_wrap_c;
  logic                  frame_end_c;
  logic [3:0]            nib_c;
  logic                  dp_cur_c;
  logic                  blank_cur_c;
  logic                  zero_above_c;
  logic                  lit_c;
  logic [31:0]           on_len_c;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex 0..F.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0:    hex_to_seg = 7'b1000000;
      4'h1:    hex_to_seg = 7'b1111001;
      4'h2:    hex_to_seg = 7'b0100100;
      4'h3:    hex_to_seg = 7'b0110000;
      4'h4:    hex_to_seg = 7'b0011001;
      4'h5:    hex_to_seg = 7'b0010010;
      4'h6:    hex_to_seg = 7'b0000010;
      4'h7:    hex_to_seg = 7'b1111000;
      4'h8:    hex_to_seg = 7'b0000000;
      4'h9:    hex_to_seg = 7'b0010000;
      4'hA:    hex_to_seg = 7'b0001000;
      4'hB:    hex_to_seg = 7'b0000011;
      4'hC:    hex_to_seg = 7'b1000110;
      4'hD:    hex_to_seg = 7'b0100001;
      4'hE:    hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  // Slot timing: tick counter and digit index.
  always_comb begin
    tick_d      = tick_q + CNT_W'(1);
    idx_d       = idx_q;
    tick_wrap_c = (tick_q == CNT_W'(TICK_DIV - 1));
    frame_end_c = tick_wrap_c && (idx_q == IDX_W'(NUM_DIGITS - 1));
    if (tick_wrap_c) begin
      tick_d = '0;
      idx_d  = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Current digit selection; blanking walks down from the top nibble so a
  // digit is blank only if it and every digit above it are zero.
  always_comb begin
    nib_c        = 4'h0;
    dp_cur_c     = 1'b0;
    blank_cur_c  = 1'b0;
    zero_above_c = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_above_c = zero_above_c && (act_val_q[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        nib_c       = act_val_q[4*i +: 4];
        dp_cur_c    = act_dp_q[i];
        blank_cur_c = act_blz_q && (i != 0) && zero_above_c;
      end
    end
  end

  // PWM on-time and next output pattern; full-width product before the shift.
  always_comb begin
    on_len_c = ((32'(act_bri_q) + 32'd1) * 32'(TICK_DIV)) >> 4;
    lit_c    = (32'(tick_q) < on_len_c) && (!blank_cur_c || dp_cur_c);
    an_d     = '1;
    seg_d    = 7'h7F;
    dp_d     = 1'b1;
    if (lit_c) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = blank_cur_c ? 7'h7F : hex_to_seg(nib_c);
      dp_d  = ~dp_cur_c;
    end
  end

  // State, shadow/active registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q    <= '0;
      idx_q     <= '0;
      sh_val_q  <= '0;
      sh_dp_q   <= '0;
      sh_blz_q  <= 1'b0;
      sh_bri_q  <= '0;
      act_val_q <= '0;
      act_dp_q  <= '0;
      act_blz_q <= 1'b0;
      act_bri_q <= '0;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      an_q      <= '1;
      fd_q      <= 1'b0;
    end else begin
      tick_q <= tick_d;
      idx_q  <= idx_d;
      if (load) begin
        sh_val_q <= value;
        sh_dp_q  <= dp_in;
        sh_blz_q <= blank_lz;
        sh_bri_q <= brightness;
      end
      // Old shadow content moves to active even if a load lands this cycle.
      if (frame_end_c) begin
        act_val_q <= sh_val_q;
        act_dp_q  <= sh_dp_q;
        act_blz_q <= sh_blz_q;
        act_bri_q <= sh_bri_q;
      end
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
      fd_q  <= frame_end_c;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl with NUM_DIGITS=4, TICK_DIV=4 (16-cycle
// frames). A per-cycle vector table covers nine frames after reset; hand
// sequences then cover reset in mid-frame and the restart afterwards.
module tb_seg7_scan_ctrl;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G6 = 7'b0000010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GB = 7'b0000011;
  localparam logic [6:0] GC = 7'b1000110;
  localparam logic [6:0] GD = 7'b0100001;
  localparam logic [6:0] GF = 7'b0001110;
  localparam logic [6:0] BL = 7'h7F;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  brightness;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        ld;
    logic [15:0] val;
    logic [3:0]  dpi;
    logic        blz;
    logic [3:0]  bri;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;
  } vec_t;

  vec_t vecs[$];

  seg7_scan_ctrl #(.NUM_DIGITS(4), .TICK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int k, input logic [3:0] e_an,
                     input logic [6:0] e_seg, input logic e_dp, input logic e_fd);
    n_checks++;
    if (an !== e_an || seg !== e_seg || dp !== e_dp || frame_done !== e_fd) begin
      n_errors++;
      $display("FAIL %s k=%0d: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
               name, k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
    end
  endtask

  // One frame of expectations: per-slot seg/an/dp packed {slot3..slot0},
  // lit for the first on_ticks ticks of each slot.
  task automatic add_frame(input logic [27:0] segs, input logic [15:0] ans,
                           input logic [3:0] dps, input int on_ticks);
    for (int s = 0; s < 4; s++) begin
      for (int t = 0; t < 4; t++) begin
        vec_t v;
        v.ld = 1'b0; v.val = '0; v.dpi = '0; v.blz = 1'b0; v.bri = '0;
        if (t < on_ticks) begin
          v.e_an  = ans[4*s +: 4];
          v.e_seg = segs[7*s +: 7];
          v.e_dp  = dps[s];
        end else begin
          v.e_an  = 4'hF;
          v.e_seg = BL;
          v.e_dp  = 1'b1;
        end
        v.e_fd = (s == 3 && t == 3);
        vecs.push_back(v);
      end
    end
  endtask

  task automatic set_load(input int k, input logic [15:0] val, input logic [3:0] dpi,
                          input logic blz, input logic [3:0] bri);
    vecs[k-1].ld  = 1'b1;
    vecs[k-1].val = val;
    vecs[k-1].dpi = dpi;
    vecs[k-1].blz = blz;
    vecs[k-1].bri = bri;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0; brightness = '0;

    // Frame table, k = edge number after reset release.
    add_frame({BL, BL, BL, BL}, 16'hFFFF, 4'hF, 0);        // 1..16   active cleared, dark
    add_frame({G3, G2, G1, G0}, 16'h7BDE, 4'hF, 4);        // 17..32  3210
    add_frame({GF, GF, GF, GF}, 16'h7BDE, 4'hF, 4);        // 33..48  FFFF, 8888 skipped
    add_frame({BL, BL, G5, G0}, 16'h7FDE, 4'b0111, 4);     // 49..64  0050 blanked
    add_frame({G0, G0, G5, G0}, 16'h7BDE, 4'b0111, 4);     // 65..80  0050 unblanked
    add_frame({G1, G2, G3, G4}, 16'h7BDE, 4'hF, 2);        // 81..96  brightness 7
    add_frame({BL, BL, BL, BL}, 16'hFFFF, 4'hF, 0);        // 97..112 brightness 0
    add_frame({GA, GB, GC, GD}, 16'h7BDE, 4'hF, 4);        // 113..128 ABCD
    add_frame({G5, G6, G7, G8}, 16'h7BDE, 4'hF, 4);        // 129..144 5678 (collision load)
    set_load(1,   16'h3210, 4'b0000, 1'b0, 4'd15);
    set_load(20,  16'h8888, 4'b0000, 1'b0, 4'd15);
    set_load(22,  16'hFFFF, 4'b0000, 1'b0, 4'd15);
    set_load(34,  16'h0050, 4'b1000, 1'b1, 4'd15);
    set_load(50,  16'h0050, 4'b1000, 1'b0, 4'd15);
    set_load(66,  16'h1234, 4'b0000, 1'b0, 4'd7);
    set_load(82,  16'h1234, 4'b0000, 1'b0, 4'd0);
    set_load(98,  16'hABCD, 4'b0000, 1'b0, 4'd15);
    set_load(112, 16'h5678, 4'b0000, 1'b0, 4'd15);         // on the wrap edge

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 0, 4'hF, BL, 1'b1, 1'b0);
    reset = 1'b0;

    for (int j = 0; j < vecs.size(); j++) begin
      load       = vecs[j].ld;
      value      = vecs[j].val;
      dp_in      = vecs[j].dpi;
      blank_lz   = vecs[j].blz;
      brightness = vecs[j].bri;
      step();
      chk("table", j + 1, vecs[j].e_an, vecs[j].e_seg, vecs[j].e_dp, vecs[j].e_fd);
    end

    // Reset while digit 2 of 5678 is being shown.
    for (int k = 145; k <= 154; k++) begin
      step();
      if (k == 153) chk("pre_reset_digit2", k, 4'b1011, G6, 1'b1, 1'b0);
    end
    reset = 1'b1;
    step();
    chk("reset_mid", 155, 4'hF, BL, 1'b1, 1'b0);
    reset = 1'b0;

    // Restart: active cleared so dark; frame timing restarts from slot 0.
    for (int kp = 1; kp <= 48; kp++) begin
      if (kp == 20) begin
        load = 1'b1; value = 16'h0009; dp_in = 4'b0000; blank_lz = 1'b1; brightness = 4'd15;
      end
      step();
      if (kp <= 32)
        chk("after_reset_dark", kp, 4'hF, BL, 1'b1, (kp == 16 || kp == 32));
      else if (kp <= 36)
        chk("after_reset_digit0", kp, 4'b1110, G9, 1'b1, 1'b0);
      else
        chk("after_reset_blanked", kp, 4'hF, BL, 1'b1, (kp == 48));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
